cluster_space_sched: RTL

//  Byte-granular task dispatcher between the MPQ engine and the per-cluster schedulers.

---
 rtl/cluster_space_sched_pkg.sv | 18 +
 rtl/cluster_space_sched_argmax.sv | 24 ++
 rtl/cluster_space_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cluster_space_sched_pkg.sv
// Shared types and defaults for the cluster packet-buffer space scheduler.
package cluster_space_sched_pkg;

  localparam int unsigned CLUSTER_BYTES = 262144;
  localparam int unsigned SIZE_W        = 16;
  localparam int unsigned CNT_W         = $clog2(CLUSTER_BYTES) + 1;
  localparam int unsigned MSGID_W       = 8;

  typedef logic [CNT_W-1:0]  free_cnt_t;
  typedef logic [SIZE_W-1:0] pkt_size_t;

  typedef struct packed {
    logic [MSGID_W-1:0] msgid;
    logic [31:0]        handler_addr;
    pkt_size_t          pkt_size;
  } handler_task_t;

endpackage

// File: rtl/cluster_space_sched_argmax.sv
// argmax_n: combinational maximum of N unsigned values; the lowest index wins ties.
module argmax_n #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic [N-1:0][W-1:0]     vals_i,
  output logic [$clog2(N)-1:0]    idx_o,
  output logic [W-1:0]            max_o
);

  localparam int unsigned IDX_W = $clog2(N);

  always_comb begin
    idx_o = '0;
    max_o = vals_i[0];
    for (int i = 1; i < N; i++) begin
      if (vals_i[i] > max_o) begin
        idx_o = IDX_W'(i);
        max_o = vals_i[i];
      end
    end
  end

endmodule

// File: rtl/cluster_space_sched.sv
// Byte-granular task dispatcher: home cluster if the packet fits, else the emptiest cluster.
// Optional SPACE_SCHED_STATS_EN adds saturating dispatch/redirect/stall counters.
//
// state     | meaning
// ST_IDLE   | ready for a task from the MPQ engine
// ST_DECIDE | pick a cluster and debit it, or stall until space is released
// ST_PUSH   | hold the dispatch until the selected cluster accepts it
module cluster_space_sched
  import cluster_space_sched_pkg::*;
#(
  parameter int unsigned  NUM_CLUSTERS  = 4,
  parameter int unsigned  CLUSTER_BYTES = cluster_space_sched_pkg::CLUSTER_BYTES,
  localparam int unsigned CNT_W         = $clog2(CLUSTER_BYTES) + 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  task_valid_i,
  output logic                                  task_ready_o,
  input  handler_task_t                         task_descr_i,
  output logic [NUM_CLUSTERS-1:0]               cluster_task_valid_o,
  input  logic [NUM_CLUSTERS-1:0]               cluster_task_ready_i,
  output handler_task_t [NUM_CLUSTERS-1:0]      cluster_task_descr_o,
  input  logic [NUM_CLUSTERS-1:0]               release_valid_i,
  input  logic [NUM_CLUSTERS-1:0][SIZE_W-1:0]   release_bytes_i,
  output logic [NUM_CLUSTERS-1:0][CNT_W-1:0]    cluster_free_o,
`ifdef SPACE_SCHED_STATS_EN
  output logic [31:0]                           stat_dispatched_o,
  output logic [31:0]                           stat_redirected_o,
  output logic [31:0]                           stat_stall_cycles_o,
`endif
  output logic                                  err_o
);

  localparam int unsigned CID_W  = $clog2(NUM_CLUSTERS);
  // Headroom so free - debit + release can never wrap before the clamp check.
  localparam int unsigned CALC_W = ((CNT_W > SIZE_W) ? CNT_W : SIZE_W) + 2;
  localparam logic [CALC_W-1:0] CAP = CALC_W'(CLUSTER_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_DECIDE, ST_PUSH} state_e;

  state_e                              state_q;
  handler_task_t                       descr_q;
  logic [CID_W-1:0]                    sel_q;
  logic [NUM_CLUSTERS-1:0][CNT_W-1:0]  free_q, free_d;
  logic [CID_W-1:0]                    home, max_idx, sel_c;
  logic [CNT_W-1:0]                    max_val;
  logic [CALC_W-1:0]                   pkt_w, sum;
  logic                                fits_home, fits_max, oversize, dispatch, ovf;

  argmax_n #(.N(NUM_CLUSTERS), .W(CNT_W)) u_argmax (
    .vals_i (free_q),
    .idx_o  (max_idx),
    .max_o  (max_val)
  );

  always_comb begin
    home      = descr_q.msgid[CID_W-1:0];
    pkt_w     = CALC_W'(descr_q.pkt_size);
    fits_home = CALC_W'(free_q[home]) >= pkt_w;
    fits_max  = CALC_W'(max_val) >= pkt_w;
    oversize  = pkt_w > CAP;
    sel_c     = fits_home ? home : max_idx;
    dispatch  = (state_q == ST_DECIDE) && !oversize && (fits_home || fits_max);
  end

  always_comb begin
    free_d = free_q;
    ovf    = 1'b0;
    sum    = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      sum = CALC_W'(free_q[i]);
      if (dispatch && (sel_c == CID_W'(i))) sum = sum - pkt_w;
      if (release_valid_i[i]) sum = sum + CALC_W'(release_bytes_i[i]);
      if (sum > CAP) begin
        free_d[i] = CNT_W'(CLUSTER_BYTES);
        ovf       = 1'b1;
      end else begin
        free_d[i] = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q              <= ST_IDLE;
      task_ready_o         <= 1'b0;
      cluster_task_valid_o <= '0;
      descr_q              <= '0;
      sel_q                <= '0;
      free_q               <= {NUM_CLUSTERS{CNT_W'(CLUSTER_BYTES)}};
      err_o                <= 1'b0;
    end else begin
      free_q <= free_d;
      if (ovf) err_o <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (task_ready_o && task_valid_i) begin
            descr_q      <= task_descr_i;
            task_ready_o <= 1'b0;
            state_q      <= ST_DECIDE;
          end else begin
            task_ready_o <= 1'b1;
          end
        end
        ST_DECIDE: begin
          if (oversize) begin
            err_o        <= 1'b1;
            task_ready_o <= 1'b1;
            state_q      <= ST_IDLE;
          end else if (dispatch) begin
            sel_q                <= sel_c;
            cluster_task_valid_o <= NUM_CLUSTERS'(1) << sel_c;
            state_q              <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (cluster_task_ready_i[sel_q]) begin
            cluster_task_valid_o <= '0;
            task_ready_o         <= 1'b1;
            state_q              <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cluster_task_descr_o = {NUM_CLUSTERS{descr_q}};
  assign cluster_free_o       = free_q;

`ifdef SPACE_SCHED_STATS_EN
  logic redir_q;
  logic push_done, stall;

  assign push_done = (state_q == ST_PUSH) && cluster_task_ready_i[sel_q];
  assign stall     = (state_q == ST_DECIDE) && !oversize && !dispatch;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redir_q             <= 1'b0;
      stat_dispatched_o   <= '0;
      stat_redirected_o   <= '0;
      stat_stall_cycles_o <= '0;
    end else begin
      if (dispatch) redir_q <= (sel_c != home);
      if (push_done && (stat_dispatched_o != '1)) stat_dispatched_o <= stat_dispatched_o + 32'd1;
      if (push_done && redir_q && (stat_redirected_o != '1))
        stat_redirected_o <= stat_redirected_o + 32'd1;
      if (stall && (stat_stall_cycles_o != '1)) stat_stall_cycles_o <= stat_stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule
